// File: rtl/sram_arb.sv
// sram_arb: two-requester arbiter in front of an 8x32 synchronous-read SRAM.
// Each granted access runs to completion: a write takes one SRAM cycle, a read
// presents the address, then captures mem_rd one cycle later into rdata.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; without it
// requester A wins every tie and no priority pointer exists.
module sram_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        we_a,
  input  logic        we_b,
  input  logic [2:0]  add_a,
  input  logic [2:0]  add_b,
  input  logic [31:0] wd_a,
  input  logic [31:0] wd_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        rvalid_a,
  output logic        rvalid_b,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [2:0]  mem_add,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWr     = 2'd1;
  localparam logic [1:0] StRdAddr = 2'd2;
  localparam logic [1:0] StRdCap  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q;
  logic [2:0]  add_q;
  logic [31:0] wd_q;
  logic        own_b_q;
  logic        gnt_a_q, gnt_b_q;
  logic        rvalid_a_q, rvalid_b_q;
  logic [31:0] rdata_q;

  logic        start;
  logic        pick_b;
  logic        sel_we;
  logic [2:0]  sel_add;
  logic [31:0] sel_wd;

  // Requests are only looked at while idle; anything seen while busy is ignored.
  assign start = (state_q == StIdle) && (req_a || req_b);

`ifdef SRAM_ARB_RR_EN
  logic ptr_q;  // 0: A preferred on a tie, 1: B preferred

  assign pick_b = req_b && (!req_a || ptr_q);

  // Pointer moves away from whoever was just granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (start) begin
      ptr_q <= !pick_b;
    end
  end
`else
  assign pick_b = req_b && !req_a;
`endif

  assign sel_we  = pick_b ? we_b  : we_a;
  assign sel_add = pick_b ? add_b : add_a;
  assign sel_wd  = pick_b ? wd_b  : wd_a;

  // Next-state decode for the access sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = sel_we ? StWr : StRdAddr;
      StWr:     state_d = StIdle;
      StRdAddr: state_d = StRdCap;
      StRdCap:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, latched request fields and the registered grant/valid pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      add_q      <= 3'd0;
      wd_q       <= 32'd0;
      own_b_q    <= 1'b0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      gnt_a_q    <= start && !pick_b;
      gnt_b_q    <= start && pick_b;
      rvalid_a_q <= (state_q == StRdCap) && !own_b_q;
      rvalid_b_q <= (state_q == StRdCap) && own_b_q;
      if (start) begin
        we_q    <= sel_we;
        add_q   <= sel_add;
        wd_q    <= sel_wd;
        own_b_q <= pick_b;
      end
      // mem_rd reflects the address presented during RD_ADDR.
      if (state_q == StRdCap) begin
        rdata_q <= mem_rd;
      end
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != StIdle);

  // SRAM side is quiet (all zero) while idle.
  assign mem_we  = (state_q == StWr);
  assign mem_add = (state_q != StIdle) ? add_q : 3'd0;
  assign mem_wd  = (state_q == StWr) ? wd_q : 32'd0;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed scenarios plus randomized two-requester traffic for
// sram_arb, checked every cycle against a transaction-level schedule model.
module tb_sram_arb;

  localparam int NCyc = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [2:0]  add_a = 3'd0, add_b = 3'd0;
  logic [31:0] wd_a = 32'd0, wd_b = 32'd0;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, busy, mem_we;
  logic [31:0] rdata, mem_wd, mem_rd;
  logic [2:0]  mem_add;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sram_arb dut (
    .clk      (clk),
    .reset    (reset),
    .req_a    (req_a),
    .req_b    (req_b),
    .we_a     (we_a),
    .we_b     (we_b),
    .add_a    (add_a),
    .add_b    (add_b),
    .wd_a     (wd_a),
    .wd_b     (wd_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .rvalid_a (rvalid_a),
    .rvalid_b (rvalid_b),
    .rdata    (rdata),
    .busy     (busy),
    .mem_add  (mem_add),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  // 8x32 SRAM with registered read data.
  logic [31:0] sram [8];
  logic [31:0] sram_rd_q;
  always @(posedge clk) begin
    if (mem_we) sram[mem_add] <= mem_wd;
    sram_rd_q <= sram[mem_add];
  end
  assign mem_rd = sram_rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: per-cycle expected outputs, scheduled per transaction.
  bit          e_ga [NCyc];
  bit          e_gb [NCyc];
  bit          e_va [NCyc];
  bit          e_vb [NCyc];
  bit          e_busy [NCyc];
  bit          e_we [NCyc];
  logic [2:0]  e_add [NCyc];
  logic [31:0] e_wd [NCyc];
  logic [31:0] e_rd [NCyc];
  logic [31:0] mmem [8];
  logic [31:0] m_rdata;

  initial begin : model
    int c, free_at;
    bit ptr, win_b, w;
    logic [2:0] a;
    logic [31:0] d;
    free_at = 0;
    ptr = 1'b0;
    m_rdata = 32'd0;
    for (int i = 0; i < 8; i++) mmem[i] = 32'd0;
    for (int i = 0; i < NCyc; i++) begin
      e_add[i] = 3'd0;
      e_wd[i]  = 32'd0;
      e_rd[i]  = 32'd0;
    end
    forever begin
      @(posedge clk);
      c = cyc;
      if (c + 4 >= NCyc) begin
        $display("FAIL model_range cyc=%0d got=%0d want<%0d", c, c + 4, NCyc);
        $fatal(1, "cycle budget exceeded");
      end
      if (reset) begin
        for (int i = c + 1; i <= c + 4; i++) begin
          e_ga[i] = 0; e_gb[i] = 0; e_va[i] = 0; e_vb[i] = 0;
          e_busy[i] = 0; e_we[i] = 0; e_add[i] = 3'd0; e_wd[i] = 32'd0;
        end
        free_at = c + 1;
        ptr = 1'b0;
        m_rdata = 32'd0;
      end else begin
        if (e_we[c]) mmem[e_add[c]] = e_wd[c];
        if (c >= free_at && (req_a || req_b)) begin
`ifdef SRAM_ARB_RR_EN
          win_b = req_b && (!req_a || ptr);
          ptr = !win_b;
`else
          win_b = req_b && !req_a;
`endif
          w = win_b ? we_b : we_a;
          a = win_b ? add_b : add_a;
          d = win_b ? wd_b : wd_a;
          e_ga[c+1] = !win_b;
          e_gb[c+1] = win_b;
          e_busy[c+1] = 1;
          e_add[c+1] = a;
          if (w) begin
            e_we[c+1] = 1;
            e_wd[c+1] = d;
            free_at = c + 2;
          end else begin
            e_busy[c+2] = 1;
            e_add[c+2] = a;
            e_va[c+3] = !win_b;
            e_vb[c+3] = win_b;
            e_rd[c+3] = mmem[a];
            free_at = c + 3;
          end
        end
        if (e_va[c+1] || e_vb[c+1]) m_rdata = e_rd[c+1];
      end
      cyc = c + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin : compare
    int c;
    forever begin
      @(negedge clk);
      c = cyc;
      if (reset) begin
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_add", 32'(mem_add), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
      end else begin
        chk("gnt_a", 32'(gnt_a), 32'(e_ga[c]));
        chk("gnt_b", 32'(gnt_b), 32'(e_gb[c]));
        chk("rvalid_a", 32'(rvalid_a), 32'(e_va[c]));
        chk("rvalid_b", 32'(rvalid_b), 32'(e_vb[c]));
        chk("busy", 32'(busy), 32'(e_busy[c]));
        chk("mem_we", 32'(mem_we), 32'(e_we[c]));
        chk("mem_add", 32'(mem_add), 32'(e_add[c]));
        if (!e_busy[c] || e_we[c]) chk("mem_wd", mem_wd, e_wd[c]);
        chk("rdata", rdata, m_rdata);
      end
    end
  end

  // Grant order log for the contention scenario.
  int glog[$];
  initial begin : grant_log
    forever begin
      @(negedge clk);
      if (!reset && gnt_a) glog.push_back(0);
      if (!reset && gnt_b) glog.push_back(1);
    end
  end

  // Raise a request, hold it until its grant is seen, drop it the cycle after.
  task automatic issue(input bit b, input bit w, input logic [2:0] a, input logic [31:0] d,
                       output int gcyc);
    if (b) begin we_b = w; add_b = a; wd_b = d; req_b = 1'b1; end
    else begin we_a = w; add_a = a; wd_a = d; req_a = 1'b1; end
    gcyc = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (b ? gnt_b : gnt_a) begin gcyc = cyc; break; end
    end
    tests++;
    if (gcyc < 0) begin
      fails++;
      $display("FAIL grant_timeout req=%0d got=none want=gnt", b);
    end
    @(posedge clk); #1;
    if (b) req_b = 1'b0; else req_a = 1'b0;
  endtask

  task automatic wait_rv(input bit b, output int vcyc, output logic [31:0] d);
    vcyc = -1;
    d = 32'd0;
    for (int n = 0; n < 20; n++) begin
      if (b ? rvalid_b : rvalid_a) begin vcyc = cyc; d = rdata; break; end
      @(posedge clk); #1;
    end
    tests++;
    if (vcyc < 0) begin
      fails++;
      $display("FAIL rvalid_timeout req=%0d got=none want=rvalid", b);
    end
  endtask

  task automatic rand_requester(input bit b, input int n_txn);
    int g;
    for (int k = 0; k < n_txn; k++) begin
      issue(b, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, g);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int rc, gc, gb, ga, vc, cnt;
    logic [31:0] d, prev;
    int exp_seq [4];

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    reset = 1'b0;

    // A writes 5 <- DEADBEEF, then reads it back.
    rc = cyc;
    issue(1'b0, 1'b1, 3'd5, 32'hDEADBEEF, gc);
    chk("wr_gnt_latency", 32'(gc - rc), 32'd1);
    chk("wr_sram_content", sram[5], 32'hDEADBEEF);
    rc = cyc;
    issue(1'b0, 1'b0, 3'd5, 32'd0, gc);
    wait_rv(1'b0, vc, d);
    chk("rd_rvalid_latency", 32'(vc - rc), 32'd3);
    chk("rd_data_deadbeef", d, 32'hDEADBEEF);

    // Fill all addresses alternating requesters, then read them all back.
    for (int i = 0; i < 8; i++) issue(1'(i), 1'b1, 3'(i), 32'hA5A50000 + 32'(i), gc);
    for (int i = 0; i < 8; i++) begin
      issue(1'(i), 1'b0, 3'(i), 32'd0, gc);
      wait_rv(1'(i), vc, d);
      chk("fill_readback", d, 32'hA5A50000 + 32'(i));
      prev = rdata;
      @(posedge clk); #1;
      chk("rdata_hold", rdata, prev);
    end

    // Continuous contention: both requesters issue four reads back to back.
    glog.delete();
    fork
      begin : cont_a
        int g1;
        for (int k = 0; k < 4; k++) issue(1'b0, 1'b0, 3'd0, 32'd0, g1);
      end
      begin : cont_b
        int g2;
        for (int k = 0; k < 4; k++) issue(1'b1, 1'b0, 3'd7, 32'd0, g2);
      end
    join
    repeat (6) @(posedge clk);
    #1;
`ifdef SRAM_ARB_RR_EN
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
    exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
    chk("contention_grants", 32'(glog.size()), 32'd8);
    if (glog.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("grant_order", 32'(glog[k]), 32'(exp_seq[k]));
    end

    // B writes 2 while A requests during the WR cycle.
    fork
      issue(1'b1, 1'b1, 3'd2, 32'h12345678, gb);
      begin : late_a
        for (int n = 0; n < 20; n++) begin
          @(posedge clk); #1;
          if (gnt_b) break;
        end
        issue(1'b0, 1'b0, 3'd2, 32'd0, ga);
      end
    join
    chk("late_a_gnt_gap", 32'(ga - gb), 32'd2);
    wait_rv(1'b0, vc, d);
    chk("late_a_data", d, 32'h12345678);

    // Reset during RD_CAP of a read to address 3.
    issue(1'b0, 1'b0, 3'd3, 32'd0, gc);
    chk("rdcap_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_mem_add", 32'(mem_add), 32'd0);
    chk("midrst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (rvalid_a || rvalid_b) cnt++;
      @(posedge clk); #1;
    end
    chk("midrst_no_rvalid", 32'(cnt), 32'd0);

    // Read immediately after a write to the same address.
    issue(1'b0, 1'b1, 3'd6, 32'hCAFE0006, gc);
    issue(1'b1, 1'b0, 3'd6, 32'd0, gc);
    wait_rv(1'b1, vc, d);
    chk("raw_data", d, 32'hCAFE0006);

    // Random traffic from both requesters with occasional resets.
    fork
      rand_requester(1'b0, 150);
      rand_requester(1'b1, 150);
      begin : rand_reset
        for (int k = 0; k < 3; k++) begin
          repeat ($urandom_range(100, 300)) @(posedge clk);
          #1 reset = 1'b1;
          repeat (2) @(posedge clk);
          #1 reset = 1'b0;
        end
      end
    join
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
